// File: rtl/game_pkg.sv
// Shared game constants: screen geometry, pixel field widths, palette and
// the enemy engine state encoding. Imported by the enemy grid engine, its
// bus interface and the sprite scanner.
package game_pkg;

  localparam int unsigned SCREEN_W = 320;
  localparam int unsigned SCREEN_H = 240;
  localparam int unsigned X_W      = 9;
  localparam int unsigned Y_W      = 8;
  localparam int unsigned C_W      = 3;

  localparam logic [C_W-1:0] BLACK  = 3'b000;
  localparam logic [C_W-1:0] BULLET = 3'b111;
  localparam logic [C_W-1:0] ENEMY  = 3'b010;
  localparam logic [C_W-1:0] USER   = 3'b001;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HIT   = 3'd1,
    ERASE = 3'd2,
    MOVE  = 3'd3,
    DRAW  = 3'd4,
    DONE  = 3'd5
  } enemy_state_e;

endpackage

// File: rtl/enemy_grid_engine_if.sv
// Control/pixel bus between the main control FSM (master) and the enemy grid
// engine (slave).
//   start, bullet_valid, bullet_x, bullet_y : step request and bullet sample
//   busy, done, hit                         : step handshake and kill pulse
//   plot, x, y, colour                      : pixel stream to the VGA mux
//   alive_count, cleared, landed            : formation status
interface enemy_grid_engine_if
  import game_pkg::*;
#(
  parameter int unsigned CNT_W = 5
);

  logic             start;
  logic             bullet_valid;
  logic [X_W-1:0]   bullet_x;
  logic [Y_W-1:0]   bullet_y;
  logic             busy;
  logic             done;
  logic             plot;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [C_W-1:0]   colour;
  logic             hit;
  logic [CNT_W-1:0] alive_count;
  logic             cleared;
  logic             landed;

  modport master (
    output start, bullet_valid, bullet_x, bullet_y,
    input  busy, done, plot, x, y, colour, hit, alive_count, cleared, landed
  );

  modport slave (
    input  start, bullet_valid, bullet_x, bullet_y,
    output busy, done, plot, x, y, colour, hit, alive_count, cleared, landed
  );

endinterface

// File: rtl/sprite_scanner.sv
// Row-major pixel walker over a SPR_W x SPR_H box at a given origin.
//   clk, resetn : clock, synchronous active-low reset
//   adv         : consume the current pixel and move to the next one
//   origin_x/y  : top-left of the box
//   px_c, py_c  : current pixel coordinate (combinational)
//   last_c      : current pixel is the final one of the box (combinational)
// The counters wrap to zero after the last pixel, so the next box starts
// without a restart cycle.
module sprite_scanner
  import game_pkg::*;
#(
  parameter int unsigned SPR_W = 20,
  parameter int unsigned SPR_H = 16
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           adv,
  input  logic [X_W-1:0] origin_x,
  input  logic [Y_W-1:0] origin_y,
  output logic [X_W-1:0] px_c,
  output logic [Y_W-1:0] py_c,
  output logic           last_c
);

  localparam int unsigned COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int unsigned ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             col_end;

  assign col_end = (col == COL_W'(SPR_W - 1));
  assign last_c  = col_end && (row == ROW_W'(SPR_H - 1));
  assign px_c    = origin_x + X_W'(col);
  assign py_c    = origin_y + Y_W'(row);

  // Column counter runs fastest; both wrap after the final pixel.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (last_c) begin
        col <= '0;
        row <= '0;
      end else if (col_end) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/enemy_grid_engine.sv
// Enemy formation engine: alive mask, marching anchor, bullet collision and
// an erase/redraw pixel stream per frame step.
//   clk, resetn : clock, synchronous active-low reset
//   bus (slave) : start/bullet request in; busy/done/hit handshake,
//                 plot/x/y/colour pixel stream and alive_count/cleared/landed out
module enemy_grid_engine
  import game_pkg::*;
#(
  parameter int unsigned    ROWS      = 2,
  parameter int unsigned    COLS      = 9,
  parameter int unsigned    SPR_W     = 20,
  parameter int unsigned    SPR_H     = 16,
  parameter int unsigned    PITCH_X   = 28,
  parameter int unsigned    PITCH_Y   = 25,
  parameter int unsigned    ANCHOR_X0 = 8,
  parameter int unsigned    ANCHOR_Y0 = 10,
  parameter int unsigned    X_MIN     = 8,
  parameter int unsigned    X_MAX     = 60,
  parameter int unsigned    STEP_X    = 1,
  parameter int unsigned    DROP_Y    = 20,
  parameter int unsigned    Y_LIMIT   = 200,
  parameter logic [C_W-1:0] COLOUR    = ENEMY
) (
  input logic                clk,
  input logic                resetn,
  enemy_grid_engine_if.slave bus
);

  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned E_W   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned R_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned K_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned A_W   = 16;
  localparam int unsigned S_W   = A_W + 1;
  localparam logic [A_W-1:0] BOTTOM_OFS = A_W'((ROWS - 1) * PITCH_Y + SPR_H);

  enemy_state_e     state, state_d;
  logic [E_W-1:0]   e_idx, e_d;
  logic [R_W-1:0]   r_idx, r_d;
  logic [K_W-1:0]   c_idx, c_d;
  logic [N-1:0]     mask, mask_d;
  logic [X_W-1:0]   anchor_x, ax_d;
  logic [Y_W-1:0]   anchor_y, ay_d;
  logic             dir_right, dir_d;
  logic             landed, landed_d;
  logic             vic_valid, vic_valid_d;
  logic [E_W-1:0]   vic_idx, vic_idx_d;
  logic [X_W-1:0]   bul_x, bul_x_d;
  logic [Y_W-1:0]   bul_y, bul_y_d;
  logic [CNT_W-1:0] alive, alive_d;
  logic             cleared_q;
  logic             busy_q, busy_d, done_q, done_d, plot_q, plot_d, hit_q, hit_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [C_W-1:0]   col_q, col_d;

  logic [A_W-1:0]   org_x, org_y, nx, ny;
  logic signed [S_W-1:0] nx_s;
  logic             bul_in_box, last_enemy, enemy_next, scan_adv;
  logic [X_W-1:0]   px_c;
  logic [Y_W-1:0]   py_c;
  logic             scan_last_c;

  // Box origin of the enemy under the cursor, at full width.
  assign org_x = A_W'(anchor_x) + A_W'(c_idx) * A_W'(PITCH_X);
  assign org_y = A_W'(anchor_y) + A_W'(r_idx) * A_W'(PITCH_Y);
  assign bul_in_box = (A_W'(bul_x) >= org_x) && (A_W'(bul_x) < org_x + A_W'(SPR_W)) &&
                      (A_W'(bul_y) >= org_y) && (A_W'(bul_y) < org_y + A_W'(SPR_H));
  assign last_enemy = (e_idx == E_W'(N - 1));

  sprite_scanner #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_scan (
    .clk      (clk),
    .resetn   (resetn),
    .adv      (scan_adv),
    .origin_x (X_W'(org_x)),
    .origin_y (Y_W'(org_y)),
    .px_c     (px_c),
    .py_c     (py_c),
    .last_c   (scan_last_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    e_d         = e_idx;
    r_d         = r_idx;
    c_d         = c_idx;
    mask_d      = mask;
    ax_d        = anchor_x;
    ay_d        = anchor_y;
    dir_d       = dir_right;
    landed_d    = landed;
    vic_valid_d = vic_valid;
    vic_idx_d   = vic_idx;
    bul_x_d     = bul_x;
    bul_y_d     = bul_y;
    alive_d     = alive;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    plot_d      = 1'b0;
    hit_d       = 1'b0;
    x_d         = x_q;
    y_d         = y_q;
    col_d       = col_q;
    enemy_next  = 1'b0;
    scan_adv    = 1'b0;
    nx          = '0;
    nx_s        = '0;
    ny          = A_W'(anchor_y);

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (landed) begin
            done_d = 1'b1;
          end else begin
            busy_d      = 1'b1;
            bul_x_d     = bus.bullet_x;
            bul_y_d     = bus.bullet_y;
            vic_valid_d = 1'b0;
            vic_idx_d   = '0;
            state_d     = bus.bullet_valid ? HIT : ERASE;
          end
        end
      end
      HIT: begin
        busy_d     = 1'b1;
        enemy_next = 1'b1;
        if (!vic_valid && mask[e_idx] && bul_in_box) begin
          vic_valid_d = 1'b1;
          vic_idx_d   = e_idx;
        end
        if (last_enemy) state_d = ERASE;
      end
      ERASE, DRAW: begin
        busy_d = 1'b1;
        if (mask[e_idx]) begin
          plot_d     = 1'b1;
          x_d        = px_c;
          y_d        = py_c;
          col_d      = (state == DRAW) ? COLOUR : BLACK;
          scan_adv   = 1'b1;
          enemy_next = scan_last_c;
        end else begin
          enemy_next = 1'b1;
        end
        if (enemy_next && last_enemy) state_d = (state == ERASE) ? MOVE : DONE;
      end
      MOVE: begin
        busy_d = 1'b1;
        if (vic_valid) begin
          mask_d[vic_idx] = 1'b0;
          alive_d         = alive - 1'b1;
        end
        if (dir_right) begin
          nx = A_W'(anchor_x) + A_W'(STEP_X);
          if (nx > A_W'(X_MAX)) begin
            ny    = ny + A_W'(DROP_Y);
            dir_d = 1'b0;
          end else begin
            ax_d = X_W'(nx);
          end
        end else begin
          // Signed so a step past zero still registers as below X_MIN.
          nx_s = signed'(S_W'(anchor_x)) - signed'(S_W'(STEP_X));
          if (nx_s < signed'(S_W'(X_MIN))) begin
            ny    = ny + A_W'(DROP_Y);
            dir_d = 1'b1;
          end else begin
            ax_d = X_W'(nx_s);
          end
        end
        ay_d = Y_W'(ny);
        if (ny + BOTTOM_OFS >= A_W'(Y_LIMIT)) landed_d = 1'b1;
        state_d = DRAW;
      end
      DONE: begin
        done_d  = 1'b1;
        hit_d   = vic_valid;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Enemy cursor walks index order, tracking row/column alongside.
    if (enemy_next) begin
      if (last_enemy) begin
        e_d = '0;
        r_d = '0;
        c_d = '0;
      end else begin
        e_d = e_idx + 1'b1;
        if (c_idx == K_W'(COLS - 1)) begin
          c_d = '0;
          r_d = r_idx + 1'b1;
        end else begin
          c_d = c_idx + 1'b1;
        end
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      e_idx     <= '0;
      r_idx     <= '0;
      c_idx     <= '0;
      mask      <= '1;
      anchor_x  <= X_W'(ANCHOR_X0);
      anchor_y  <= Y_W'(ANCHOR_Y0);
      dir_right <= 1'b1;
      landed    <= 1'b0;
      vic_valid <= 1'b0;
      vic_idx   <= '0;
      bul_x     <= '0;
      bul_y     <= '0;
      alive     <= CNT_W'(N);
      cleared_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      plot_q    <= 1'b0;
      hit_q     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      col_q     <= '0;
    end else begin
      state     <= state_d;
      e_idx     <= e_d;
      r_idx     <= r_d;
      c_idx     <= c_d;
      mask      <= mask_d;
      anchor_x  <= ax_d;
      anchor_y  <= ay_d;
      dir_right <= dir_d;
      landed    <= landed_d;
      vic_valid <= vic_valid_d;
      vic_idx   <= vic_idx_d;
      bul_x     <= bul_x_d;
      bul_y     <= bul_y_d;
      alive     <= alive_d;
      cleared_q <= (alive_d == '0);
      busy_q    <= busy_d;
      done_q    <= done_d;
      plot_q    <= plot_d;
      hit_q     <= hit_d;
      x_q       <= x_d;
      y_q       <= y_d;
      col_q     <= col_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.plot        = plot_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.colour      = col_q;
  assign bus.hit         = hit_q;
  assign bus.alive_count = alive;
  assign bus.cleared     = cleared_q;
  assign bus.landed      = landed;

endmodule

// File: doc/enemy_grid_engine.md
Name: enemy_grid_engine

Overview:
Parametrised successor to the fixed 9x2 enemy logic in the game datapath. Owns a ROWS x COLS enemy formation with a per-enemy alive mask, marching movement (edge reversal plus drop), and bullet collision. On each frame step it emits a one-pixel-per-cycle erase/redraw stream for the shared VGA mux (320x240, 3-bit colour). Driven by the main control FSM with a start/done handshake.

Parameters:
ROWS, 2, formation rows (1..8)
COLS, 9, formation columns (1..16)
SPR_W, 20, sprite width in pixels
SPR_H, 16, sprite height in pixels
PITCH_X, 28, column pitch in pixels (>= SPR_W)
PITCH_Y, 25, row pitch in pixels (>= SPR_H)
ANCHOR_X0, 8, reset anchor x (top-left of enemy [0][0])
ANCHOR_Y0, 10, reset anchor y
X_MIN, 8, minimum anchor x
X_MAX, 60, maximum anchor x
STEP_X, 1, horizontal step per frame
DROP_Y, 20, vertical drop on reversal
Y_LIMIT, 200, landing line
COLOUR, 3'b010, sprite colour

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
start  in  1  one-cycle pulse: run one frame step
bullet_valid  in  1  bullet is live; sampled with start
bullet_x  in  9  bullet x; sampled with start
bullet_y  in  8  bullet y; sampled with start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at the end of a step
plot  out  1  pixel valid
x  out  9  pixel x
y  out  8  pixel y
colour  out  3  pixel colour; 3'b000 during erase
hit  out  1  one-cycle pulse in the same cycle as done if an enemy was killed this step
alive_count  out  $clog2(ROWS*COLS+1)  number of live enemies
cleared  out  1  alive_count == 0
landed  out  1  sticky; formation bottom has reached Y_LIMIT

Behaviour:
- Reset: state IDLE; alive mask all ones; anchor = (ANCHOR_X0, ANCHOR_Y0); direction right; busy, done, plot, hit, landed = 0; x, y, colour = 0; alive_count = ROWS*COLS.
- Enemy index e = r*COLS + c. Box origin: (anchor_x + c*PITCH_X, anchor_y + r*PITCH_Y). Coordinates are computed at full width and then truncated to 9/8 bits.
- States:
  - IDLE: accepts start only when landed == 0. If landed == 1, start produces a done pulse in the next cycle with no pixels and no movement. start while busy is ignored.
  - HIT: one cycle per enemy in index order. The first alive enemy whose box contains the bullet point (inclusive origin, exclusive origin+SPR_W/SPR_H) is latched as the victim. At most one kill per step. Skipped when bullet_valid == 0.
  - ERASE: for each enemy in index order: if alive (the victim counts as alive here), scan SPR_H rows x SPR_W columns, row-major, one pixel per cycle, plot = 1, colour = 0. Dead enemies cost one cycle with plot = 0.
  - MOVE: one cycle, plot = 0. The victim's alive bit is cleared here.
    - Direction right: if anchor_x + STEP_X > X_MAX, then anchor_y += DROP_Y and direction flips to left; otherwise anchor_x += STEP_X.
    - Direction left: mirror of the above using X_MIN, with anchor_x - STEP_X compared at signed width.
    - landed is set if anchor_y_new + (ROWS-1)*PITCH_Y + SPR_H >= Y_LIMIT.
  - DRAW: same scan as ERASE using the new mask and anchor, colour = COLOUR.
  - DONE: done = 1, busy = 0, hit = 1 if a victim was latched. Returns to IDLE.
- Cycle count per step = 1 (accept) + N (HIT, or 0 if skipped) + scan(ERASE) + 1 (MOVE) + scan(DRAW) + 1 (DONE), where N = ROWS*COLS and scan = alive*SPR_W*SPR_H + dead.
- If cleared is set, the step still moves the anchor; ERASE and DRAW each cost N cycles with no plots.
- Reset asserted mid-step aborts immediately to reset values. No partial pixels follow.
- plot is high only in ERASE/DRAW pixel cycles; x, y, colour are valid whenever plot is high.

Decomposition:
- Shared package game_pkg: SCREEN_W = 320, SCREEN_H = 240, X_W = 9, Y_W = 8, colour constants (BLACK, BULLET, ENEMY, USER), enemy state enum (IDLE, HIT, ERASE, MOVE, DRAW, DONE).
- Sub-module sprite_scanner: given origin, SPR_W and SPR_H, and a go pulse, outputs a row-major pixel x/y with a last flag. Reused later by the user and bullet renderers.

Test Plan:
- ROWS=2, COLS=3, SPR 4x4, no bullet, start -> busy for 1+0+96+1+96+1 cycles; 96 erase plots colour 0, then 96 draw plots; anchor (8,10) -> (9,10); done pulse; hit = 0.
- Anchor x = 60, direction right, start -> anchor (60,30); direction left; the next step gives anchor x = 59.
- bullet (9,11) valid at start -> enemy 0 erased, not redrawn; draw phase has 80 plots; hit pulses with done; alive_count 6 -> 5.
- Bullet inside the overlap point of no box (gap pixel x = anchor_x + 5) -> no kill, hit = 0; a bullet covering two boxes is impossible by pitch, so also check that the first-index victim is chosen when hitting the enemy [1][0] origin.
- Drop anchor y to within range so the bottom reaches 200 -> landed = 1; the next start gives done after 1 cycle with no plots.
- Assert reset at draw pixel 40 -> plot = 0 next cycle, alive all ones, anchor (8,10), busy = 0.
